// File: rtl/pinmux_ctrl.sv
// pinmux_ctrl: per-pad output multiplexer with a safe reprogramming sequence.
// Each pad holds a registered source select: 0 = idle, k = peripheral k-1.
// A reprogram request is sampled only in IDLE. Invalid requests get a one-cycle
// error ack. Valid requests quiesce the target pad's OE for SettleCycles cycles
// (DRAIN), then write the entry and ack in COMMIT.
//
// Optional feature: define PINMUX_LOCK_EN to add a sticky per-pad lock bit.
// The lock bit is set on commit with cfg_lock_i=1 and is cleared only by reset.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_req_i             reprogram request (sampled in IDLE only)
//   cfg_pad_i/sel_i/lock_i target pad, source select, lock-on-commit
//   cfg_ack_o, cfg_err_o  one-cycle completion pulse, reject flag
//   busy_o                high while a sequence is in flight
//   periph_out_i/oe_i     peripheral data and output enables
//   pad_out_o/oe_o        padring data and output enables
module pinmux_ctrl #(
    parameter int NPads        = 64,
    parameter int NPeriph      = 16,
    parameter int SettleCycles = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_req_i,
    input  logic [7:0]         cfg_pad_i,
    input  logic [4:0]         cfg_sel_i,
    input  logic               cfg_lock_i,
    output logic               cfg_ack_o,
    output logic               cfg_err_o,
    output logic               busy_o,
    input  logic [NPeriph-1:0] periph_out_i,
    input  logic [NPeriph-1:0] periph_oe_i,
    output logic [NPads-1:0]   pad_out_o,
    output logic [NPads-1:0]   pad_oe_o
);

    localparam int SelW = $clog2(NPeriph + 1);

    if (SettleCycles < 1 || SettleCycles > 255) begin : g_bad_settle
        $error("pinmux_ctrl: SettleCycles must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REJECT} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q;
    logic [7:0]      cap_pad_q;
    logic [4:0]      cap_sel_q;
    logic [SelW-1:0] sel_q [NPads];
    logic            pad_locked;
    logic            req_bad;

`ifdef PINMUX_LOCK_EN
    logic             cap_lock_q;
    logic [NPads-1:0] lock_q;
`else
    logic             lock_unused;
    assign lock_unused = cfg_lock_i;
`endif

    // Validity of the request currently presented on the cfg_* inputs.
    always_comb begin
        pad_locked = 1'b0;
`ifdef PINMUX_LOCK_EN
        for (int unsigned p = 0; p < NPads; p++) begin
            if (cfg_pad_i == 8'(p) && lock_q[p]) pad_locked = 1'b1;
        end
`endif
        req_bad = (32'(cfg_pad_i) >= 32'(NPads)) ||
                  (32'(cfg_sel_i) > 32'(NPeriph)) || pad_locked;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cfg_req_i) state_d = req_bad ? REJECT : DRAIN;
            DRAIN:   if (cnt_q == 8'(SettleCycles - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, settle counter and select table
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            cap_pad_q <= '0;
            cap_sel_q <= '0;
            for (int unsigned p = 0; p < NPads; p++) sel_q[p] <= '0;
        end else begin
            if (state_q == IDLE && cfg_req_i) begin
                cap_pad_q <= cfg_pad_i;
                cap_sel_q <= cfg_sel_i;
                cnt_q     <= '0;
            end
            if (state_q == DRAIN) cnt_q <= cnt_q + 8'd1;
            if (state_q == COMMIT) begin
                for (int unsigned p = 0; p < NPads; p++) begin
                    if (cap_pad_q == 8'(p)) sel_q[p] <= SelW'(cap_sel_q);
                end
            end
        end
    end

`ifdef PINMUX_LOCK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_lock_q <= 1'b0;
            lock_q     <= '0;
        end else begin
            if (state_q == IDLE && cfg_req_i) cap_lock_q <= cfg_lock_i;
            if (state_q == COMMIT && cap_lock_q) begin
                for (int unsigned p = 0; p < NPads; p++) begin
                    if (cap_pad_q == 8'(p)) lock_q[p] <= 1'b1;
                end
            end
        end
    end
`endif

    // Outputs. Bit 0 of the extended vectors is the idle source, so a
    // select value indexes them directly.
    logic [NPeriph:0] ext_out, ext_oe;
    logic             force_oe;

    always_comb begin
        cfg_ack_o = (state_q == COMMIT) || (state_q == REJECT);
        cfg_err_o = (state_q == REJECT);
        busy_o    = (state_q != IDLE);
        force_oe  = (state_q == DRAIN) || (state_q == COMMIT);
        ext_out   = {periph_out_i, 1'b0};
        ext_oe    = {periph_oe_i, 1'b0};
        pad_out_o = '0;
        pad_oe_o  = '0;
        for (int unsigned p = 0; p < NPads; p++) begin
            pad_out_o[p] = ext_out[sel_q[p]];
            pad_oe_o[p]  = ext_oe[sel_q[p]] && !(force_oe && cap_pad_q == 8'(p));
        end
    end

endmodule

// File: tb/tb_pinmux_ctrl.sv
module tb_pinmux_ctrl;

    localparam int S = 4;
`ifdef PINMUX_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [7:0]  cfg_pad;
    logic [4:0]  cfg_sel;
    logic        cfg_lock;
    logic        cfg_ack, cfg_err, busy;
    logic [15:0] periph_out, periph_oe;
    logic [63:0] pad_out, pad_oe;

    int total = 0;
    int bad   = 0;

    // Reference model: select value and lock flag per pad.
    int m_sel  [64];
    bit m_lock [64];

    pinmux_ctrl #(.NPads(64), .NPeriph(16), .SettleCycles(S)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(cfg_req), .cfg_pad_i(cfg_pad), .cfg_sel_i(cfg_sel),
        .cfg_lock_i(cfg_lock), .cfg_ack_o(cfg_ack), .cfg_err_o(cfg_err),
        .busy_o(busy), .periph_out_i(periph_out), .periph_oe_i(periph_oe),
        .pad_out_o(pad_out), .pad_oe_o(pad_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] m_route(input logic [15:0] src);
        logic [63:0] r;
        for (int p = 0; p < 64; p++) r[p] = (m_sel[p] == 0) ? 1'b0 : src[m_sel[p] - 1];
        return r;
    endfunction

    function automatic void m_reset();
        for (int p = 0; p < 64; p++) begin
            m_sel[p]  = 0;
            m_lock[p] = 1'b0;
        end
    endfunction

    // Advance one clock; outputs are observed 2 time units after the edge.
    task automatic step(input bit rnd = 1'b1);
        @(posedge clk);
        #1;
        if (rnd) begin
            periph_out = 16'($urandom);
            periph_oe  = 16'($urandom);
        end
        #1;
    endtask

    // One request, checked cycle by cycle against the model.
    task automatic run_request(input int pad, input int sel, input bit lock, input bit extra);
        bit          rej;
        logic [63:0] eo, eoe;
        rej = (pad >= 64) || (sel > 16) || (LOCK_EN && pad < 64 && m_lock[pad]);
        cfg_req = 1'b1; cfg_pad = 8'(pad); cfg_sel = 5'(sel); cfg_lock = lock;
        step();
        if (rej) begin
            cfg_req = 1'b0;
            total++;
            if ({busy, cfg_ack, cfg_err} !== 3'b111) begin
                bad++;
                $display("FAIL reject_status pad=%0d sel=%0d: got %b want 111", pad, sel, {busy, cfg_ack, cfg_err});
            end
            eo = m_route(periph_out); eoe = m_route(periph_oe);
            total++;
            if ({pad_out, pad_oe} !== {eo, eoe}) begin
                bad++;
                $display("FAIL reject_pads: got %h want %h", {pad_out, pad_oe}, {eo, eoe});
            end
            step();
        end else begin
            for (int c = 1; c <= S + 1; c++) begin
                eo = m_route(periph_out); eoe = m_route(periph_oe);
                eoe[pad] = 1'b0;
                total++;
                if ({busy, cfg_ack, cfg_err} !== ((c <= S) ? 3'b100 : 3'b110)) begin
                    bad++;
                    $display("FAIL seq_status cycle=%0d: got %b want %b", c, {busy, cfg_ack, cfg_err},
                             (c <= S) ? 3'b100 : 3'b110);
                end
                total++;
                if ({pad_out, pad_oe} !== {eo, eoe}) begin
                    bad++;
                    $display("FAIL seq_pads cycle=%0d: got %h want %h", c, {pad_out, pad_oe}, {eo, eoe});
                end
                if (extra && c < S) begin
                    cfg_req = 1'b1;
                    cfg_pad = 8'($urandom_range(0, 63));
                    cfg_sel = 5'($urandom_range(0, 16));
                end else begin
                    cfg_req = 1'b0;
                end
                step();
            end
            m_sel[pad] = sel;
            if (LOCK_EN && lock) m_lock[pad] = 1'b1;
        end
        total++;
        if ({busy, cfg_ack, cfg_err} !== 3'b000) begin
            bad++;
            $display("FAIL idle_status after pad=%0d: got %b want 000", pad, {busy, cfg_ack, cfg_err});
        end
        eo = m_route(periph_out); eoe = m_route(periph_oe);
        total++;
        if ({pad_out, pad_oe} !== {eo, eoe}) begin
            bad++;
            $display("FAIL idle_pads after pad=%0d: got %h want %h", pad, {pad_out, pad_oe}, {eo, eoe});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_req = 1'b1; cfg_pad = 8'd2; cfg_sel = 5'd1; cfg_lock = 1'b0;
        periph_out = 16'h0001; periph_oe = 16'h0001;
        step(1'b0);
        step(1'b0);
        rst = 1'b0; cfg_req = 1'b0;
        m_reset();
        total++;
        if ({busy, cfg_ack, cfg_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_status: got %b want 000", {busy, cfg_ack, cfg_err});
        end
        total++;
        if ({pad_out, pad_oe} !== 128'd0) begin
            bad++;
            $display("FAIL reset_pads: got %h want 0", {pad_out, pad_oe});
        end
        step(1'b0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_req_ignored: busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        run_request(5, 1, 1'b0, 1'b0);
        total++;
        if ({pad_out[5], pad_oe[5]} !== {periph_out[0], periph_oe[0]}) begin
            bad++;
            $display("FAIL basic_pad5: got %b want %b", {pad_out[5], pad_oe[5]}, {periph_out[0], periph_oe[0]});
        end
    endtask

    task automatic test_same_value();
        run_request(5, 1, 1'b0, 1'b0);
        run_request(9, 16, 1'b0, 1'b0);
        run_request(63, 7, 1'b0, 1'b0);
    endtask

    task automatic test_reject();
        run_request(70, 1, 1'b0, 1'b0);
        run_request(5, 17, 1'b0, 1'b0);
        run_request(64, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_request(12, 4, 1'b0, 1'b1);
        run_request(13, 0, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        cfg_req = 1'b1; cfg_pad = 8'd7; cfg_sel = 5'd3; cfg_lock = 1'b0;
        step();
        cfg_req = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({busy, cfg_ack, cfg_err, pad_out, pad_oe} !== 131'd0) begin
                bad++;
                $display("FAIL abort_idle cycle=%0d: got %b%b%b %h want all 0", i, busy, cfg_ack, cfg_err,
                         {pad_out, pad_oe});
            end
            step();
        end
        run_request(7, 3, 1'b0, 1'b0);
    endtask

    task automatic test_lock();
        run_request(3, 2, 1'b1, 1'b0);
        run_request(3, 0, 1'b0, 1'b0);
        total++;
        if (pad_out[3] !== (LOCK_EN ? periph_out[1] : 1'b0)) begin
            bad++;
            $display("FAIL lock_pad3: got %b want %b", pad_out[3], LOCK_EN ? periph_out[1] : 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_request(int'($urandom_range(0, 79)), int'($urandom_range(0, 20)),
                        ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic();
        test_same_value();
        test_reject();
        test_back_to_back();
        test_abort();
        test_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
